// File: rtl/mips_ctrl_pkg.sv
// Shared pipeline-control definitions for the MIPS core: stall vector layout,
// canonical stall patterns and the sequencing FSM state encoding.
package mips_ctrl_pkg;

    localparam int STALL_PC    = 0;
    localparam int STALL_IFID  = 1;
    localparam int STALL_IDEX  = 2;
    localparam int STALL_EXMEM = 3;
    localparam int STALL_MEMWB = 4;
    localparam int STALL_W     = STALL_MEMWB + 1;

    // A stalled stage implies every earlier stage is stalled, so every legal
    // pattern is a run of ones from the pc up to the last held stage.
    function automatic logic [STALL_W-1:0] stall_thru(input int last);
        logic [STALL_W-1:0] mask;
        mask = '0;
        for (int i = STALL_PC; i < STALL_W; i++) begin
            if (i <= last) mask[i] = 1'b1;
        end
        return mask;
    endfunction

    localparam logic [STALL_W-1:0] STALL_NONE = '0;
    localparam logic [STALL_W-1:0] STALL_LU   = stall_thru(STALL_IFID);
    localparam logic [STALL_W-1:0] STALL_MC   = stall_thru(STALL_IDEX);
    localparam logic [STALL_W-1:0] STALL_ALL  = stall_thru(STALL_EXMEM + 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MC_RUN  = 2'd1,
        ST_MC_DONE = 2'd2,
        ST_FLUSH   = 2'd3
    } ctrl_state_e;

endpackage

// File: rtl/mc_counter.sv
// Loadable down-counter used to time multi-cycle execute operations.
// Holds at zero instead of wrapping so a late dec cannot re-arm it.
module mc_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: merges load-use, multi-cycle ex and flush
// requests into stage hold enables. PIPE_CTRL_PERF_EN adds a stall-cycle counter.
module pipe_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int EX_MC_CYCLES = 32,
    parameter int CNT_W        = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               id_stall_req,
    input  logic               ex_mc_start,
    input  logic               ex_mc_cancel,
    input  logic               flush_req,
    output logic [STALL_W-1:0] stall,
    output logic               flush,
    output logic               mc_busy,
`ifdef PIPE_CTRL_PERF_EN
    input  logic               perf_clr,
    output logic [31:0]        stall_cycles,
`endif
    output logic               mc_done
);

    // state      | meaning
    // IDLE       | no op in flight; stall follows id/ex/flush requests
    // MC_RUN     | multi-cycle ex op counting down, front end held
    // MC_DONE    | ex result valid, ex_mem captures it this cycle
    // FLUSH      | flush pulse to all pipeline registers

    localparam logic [CNT_W-1:0] MC_LOAD = CNT_W'(EX_MC_CYCLES - 1);

    ctrl_state_e        state_q;
    ctrl_state_e        state_d;
    logic [STALL_W-1:0] stall_d;
    logic               cnt_load;
    logic               cnt_dec;
    logic               cnt_zero;

    mc_counter #(
        .CNT_W (CNT_W)
    ) u_mc_counter (
        .clk        (clk),
        .rst        (rst),
        .load_i     (cnt_load),
        .load_val_i (MC_LOAD),
        .dec_i      (cnt_dec),
        .zero_o     (cnt_zero)
    );

    always_comb begin
        state_d  = state_q;
        stall_d  = STALL_NONE;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (flush_req) begin
                    state_d = ST_FLUSH;
                end else if (ex_mc_start) begin
                    stall_d  = STALL_MC;
                    cnt_load = 1'b1;
                    state_d  = ST_MC_RUN;
                end else if (id_stall_req) begin
                    stall_d = STALL_LU;
                end
            end
            ST_MC_RUN: begin
                stall_d = STALL_MC;
                cnt_dec = 1'b1;
                if (flush_req || ex_mc_cancel) begin
                    state_d = ST_FLUSH;
                end else if (cnt_zero) begin
                    state_d = ST_MC_DONE;
                end
            end
            // ex_mc_start is still high here for the op just completed
            ST_MC_DONE: begin
                state_d = flush_req ? ST_FLUSH : ST_IDLE;
            end
            ST_FLUSH: begin
                state_d = flush_req ? ST_FLUSH : ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign stall   = rst ? STALL_NONE : stall_d;
    assign flush   = (state_q == ST_FLUSH);
    assign mc_busy = (state_q == ST_MC_RUN);
    // A flush arriving with the result squashes the commit
    assign mc_done = (state_q == ST_MC_DONE) && !flush_req;

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cycles_q;
    logic [31:0] stall_cycles_d;

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (perf_clr) begin
            stall_cycles_d = '0;
        end else if (stall[STALL_PC] && (stall_cycles_q != 32'hFFFF_FFFF)) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles_q <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl (EX_MC_CYCLES=4): table-driven vectors plus
// hand sequences for cancel, held flush and flush-at-done; expectations via a queue.
module tb_pipe_ctrl;

    logic       clk;
    logic       rst;
    logic       id_stall_req;
    logic       ex_mc_start;
    logic       ex_mc_cancel;
    logic       flush_req;
    logic [4:0] stall;
    logic       flush;
    logic       mc_busy;
    logic       mc_done;
`ifdef PIPE_CTRL_PERF_EN
    logic        perf_clr;
    logic [31:0] stall_cycles;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        rst;
        logic        id;
        logic        st;
        logic        cn;
        logic        fr;
        logic        pclr;
        logic [4:0]  e_stall;
        logic        e_flush;
        logic        e_busy;
        logic        e_done;
        logic [31:0] e_perf;
        logic        chk_perf;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];

    pipe_ctrl #(
        .EX_MC_CYCLES (4),
        .CNT_W        (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .id_stall_req (id_stall_req),
        .ex_mc_start  (ex_mc_start),
        .ex_mc_cancel (ex_mc_cancel),
        .flush_req    (flush_req),
        .stall        (stall),
        .flush        (flush),
        .mc_busy      (mc_busy),
`ifdef PIPE_CTRL_PERF_EN
        .perf_clr     (perf_clr),
        .stall_cycles (stall_cycles),
`endif
        .mc_done      (mc_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    function automatic vec_t mk(input logic r, input logic id, input logic st,
                                input logic cn, input logic fr, input logic pc,
                                input logic [4:0] es, input logic ef, input logic eb,
                                input logic ed, input int ep, input logic cp);
        vec_t v;
        v.rst = r; v.id = id; v.st = st; v.cn = cn; v.fr = fr; v.pclr = pc;
        v.e_stall = es; v.e_flush = ef; v.e_busy = eb; v.e_done = ed;
        v.e_perf = 32'(ep); v.chk_perf = cp;
        return v;
    endfunction

    task automatic chk(input string tag, input int step, input string nm,
                       input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s[%0d] %s: got %0h expected %0h", tag, step, nm, got, exp);
        end
    endtask

    task automatic apply(input vec_t v, input string tag, input int step);
        vec_t e;
        @(posedge clk);
        #1;
        rst          = v.rst;
        id_stall_req = v.id;
        ex_mc_start  = v.st;
        ex_mc_cancel = v.cn;
        flush_req    = v.fr;
`ifdef PIPE_CTRL_PERF_EN
        perf_clr     = v.pclr;
`endif
        exp_q.push_back(v);
        @(negedge clk);
        e = exp_q.pop_front();
        chk(tag, step, "stall",   32'(stall),   32'(e.e_stall));
        chk(tag, step, "flush",   32'(flush),   32'(e.e_flush));
        chk(tag, step, "mc_busy", 32'(mc_busy), 32'(e.e_busy));
        chk(tag, step, "mc_done", 32'(mc_done), 32'(e.e_done));
`ifdef PIPE_CTRL_PERF_EN
        if (e.chk_perf) chk(tag, step, "stall_cycles", stall_cycles, e.e_perf);
`endif
    endtask

    initial begin
        rst = 1'b1; id_stall_req = 1'b0; ex_mc_start = 1'b0;
        ex_mc_cancel = 1'b0; flush_req = 1'b0;
`ifdef PIPE_CTRL_PERF_EN
        perf_clr = 1'b0;
`endif
        //            rst id st cn fr pc  stall    fl bz dn perf chk
        tbl.push_back(mk(1, 1, 0, 0, 1, 0, 5'b00000, 0, 0, 0, 0, 1));
        tbl.push_back(mk(1, 0, 1, 0, 0, 0, 5'b00000, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 5'b00000, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 5'b00011, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 5'b00000, 0, 0, 0, 1, 1));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 5'b00111, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 5'b00111, 0, 1, 0, 1, 1));
        tbl.push_back(mk(0, 1, 1, 0, 0, 0, 5'b00111, 0, 1, 0, 2, 1));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 5'b00111, 0, 1, 0, 3, 1));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 5'b00111, 0, 1, 0, 4, 1));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 5'b00000, 0, 0, 1, 5, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 5'b00000, 0, 0, 0, 5, 1));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 5'b00000, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 5'b00000, 0, 0, 0, 0, 1));
        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], "table", i);

        // flush_req together with start in IDLE, then held for 3 cycles
        apply(mk(0, 0, 1, 0, 1, 0, 5'b00000, 0, 0, 0, 0, 0), "flush", 0);
        apply(mk(0, 0, 0, 0, 1, 0, 5'b00000, 1, 0, 0, 0, 0), "flush", 1);
        apply(mk(0, 0, 0, 0, 1, 0, 5'b00000, 1, 0, 0, 0, 0), "flush", 2);
        apply(mk(0, 1, 1, 0, 0, 0, 5'b00000, 1, 0, 0, 0, 0), "flush", 3);
        apply(mk(0, 0, 0, 0, 0, 0, 5'b00000, 0, 0, 0, 0, 0), "flush", 4);

        // cancel two cycles into a run
        apply(mk(0, 0, 1, 0, 0, 0, 5'b00111, 0, 0, 0, 0, 0), "cancel", 0);
        apply(mk(0, 0, 1, 0, 0, 0, 5'b00111, 0, 1, 0, 0, 0), "cancel", 1);
        apply(mk(0, 0, 1, 1, 0, 0, 5'b00111, 0, 1, 0, 0, 0), "cancel", 2);
        apply(mk(0, 0, 1, 0, 0, 0, 5'b00000, 1, 0, 0, 0, 0), "cancel", 3);
        apply(mk(0, 0, 0, 0, 0, 0, 5'b00000, 0, 0, 0, 0, 0), "cancel", 4);

        // flush arriving in the done cycle squashes mc_done
        apply(mk(0, 0, 1, 0, 0, 0, 5'b00111, 0, 0, 0, 0, 0), "donefl", 0);
        for (int i = 1; i <= 4; i++)
            apply(mk(0, 0, 1, 0, 0, 0, 5'b00111, 0, 1, 0, 0, 0), "donefl", i);
        apply(mk(0, 0, 1, 0, 1, 0, 5'b00000, 0, 0, 0, 0, 0), "donefl", 5);
        apply(mk(0, 0, 0, 0, 0, 0, 5'b00000, 1, 0, 0, 0, 0), "donefl", 6);
        apply(mk(0, 0, 0, 0, 0, 0, 5'b00000, 0, 0, 0, 0, 0), "donefl", 7);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
